// File: rtl/crack_sched.sv
// Scheduler for NUM_ENG RC4 crack engines: launch, CT memory arbitration, PT forwarding.
// Define CRACK_SCHED_RR_EN for round-robin CT arbitration; otherwise fixed priority (lowest index wins).
module crack_sched #(
  parameter int NUM_ENG = 2,
  parameter int KEY_W   = 24,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic                        rdy,
  output logic [KEY_W-1:0]            key,
  output logic                        key_valid,
  output logic [NUM_ENG-1:0]          eng_en,
  output logic [NUM_ENG*KEY_W-1:0]    eng_start_key,
  input  logic [NUM_ENG-1:0]          eng_rdy,
  input  logic [NUM_ENG*KEY_W-1:0]    eng_key,
  input  logic [NUM_ENG-1:0]          eng_key_valid,
  input  logic [NUM_ENG-1:0]          eng_ct_req,
  input  logic [NUM_ENG*ADDR_W-1:0]   eng_ct_addr,
  output logic [NUM_ENG-1:0]          eng_ct_gnt,
  output logic [NUM_ENG-1:0]          eng_ct_rvalid,
  output logic [DATA_W-1:0]           eng_ct_rddata,
  output logic [ADDR_W-1:0]           ct_addr,
  input  logic [DATA_W-1:0]           ct_rddata,
  input  logic [NUM_ENG-1:0]          eng_fpt_wren,
  input  logic [NUM_ENG*ADDR_W-1:0]   eng_fpt_addr,
  input  logic [NUM_ENG*DATA_W-1:0]   eng_fpt_wrdata,
  output logic                        fpt_wren,
  output logic [ADDR_W-1:0]           fpt_addr,
  output logic [DATA_W-1:0]           fpt_wrdata
);

  localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_ARM, ST_RUN} state_t;

  state_t               state_r;
  logic                 owner_v_r;
  logic [IDX_W-1:0]     owner_r;
  logic                 owner_v_s;
  logic [IDX_W-1:0]     owner_s;
  logic [IDX_W-1:0]     wr_low_s;
  logic                 gnt_v_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic [ADDR_W-1:0]    ct_addr_r;
  logic [NUM_ENG-1:0]   rvalid_r;

  logic [KEY_W-1:0]     eng_key_a   [NUM_ENG];
  logic [ADDR_W-1:0]    ct_addr_a   [NUM_ENG];
  logic [ADDR_W-1:0]    fpt_addr_a  [NUM_ENG];
  logic [DATA_W-1:0]    fpt_data_a  [NUM_ENG];

  for (genvar i = 0; i < NUM_ENG; i++) begin : g_slice
    assign eng_start_key[i*KEY_W +: KEY_W] = KEY_W'(i);
    assign eng_key_a[i]  = eng_key[i*KEY_W +: KEY_W];
    assign ct_addr_a[i]  = eng_ct_addr[i*ADDR_W +: ADDR_W];
    assign fpt_addr_a[i] = eng_fpt_addr[i*ADDR_W +: ADDR_W];
    assign fpt_data_a[i] = eng_fpt_wrdata[i*DATA_W +: DATA_W];
  end

  // Lowest-index PT writer this cycle
  always_comb begin
    wr_low_s = {IDX_W{1'b0}};
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      wr_low_s = eng_fpt_wren[i] ? IDX_W'(i) : wr_low_s;
    end
  end

  // Effective owner: the locked one, or the first writer seen in RUN so its first byte is not lost
  always_comb begin
    if (owner_v_r) begin
      owner_v_s = 1'b1;
      owner_s   = owner_r;
    end else if ((state_r == ST_RUN) && (|eng_fpt_wren)) begin
      owner_v_s = 1'b1;
      owner_s   = wr_low_s;
    end else begin
      owner_v_s = 1'b0;
      owner_s   = {IDX_W{1'b0}};
    end
  end

  assign fpt_wren   = owner_v_s & eng_fpt_wren[owner_s];
  assign fpt_addr   = fpt_addr_a[owner_s];
  assign fpt_wrdata = fpt_data_a[owner_s];

`ifdef CRACK_SCHED_RR_EN
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W:0]   rr_sum_s;
  logic [IDX_W-1:0] rr_cand_s;

  // Round-robin pick: search from rr_ptr upward, wrapping; later loop passes have higher priority
  always_comb begin
    gnt_idx_s = {IDX_W{1'b0}};
    rr_sum_s  = {(IDX_W+1){1'b0}};
    rr_cand_s = {IDX_W{1'b0}};
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      rr_sum_s  = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
      rr_cand_s = (rr_sum_s >= (IDX_W+1)'(NUM_ENG)) ?
                  IDX_W'(rr_sum_s - (IDX_W+1)'(NUM_ENG)) : rr_sum_s[IDX_W-1:0];
      gnt_idx_s = eng_ct_req[rr_cand_s] ? rr_cand_s : gnt_idx_s;
    end
  end

  // Pointer advances past the engine just granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {IDX_W{1'b0}};
    end else if (gnt_v_s) begin
      rr_ptr_r <= (gnt_idx_s == IDX_W'(NUM_ENG - 1)) ? {IDX_W{1'b0}} : gnt_idx_s + IDX_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority pick: lowest requesting index
  always_comb begin
    gnt_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      gnt_idx_s = eng_ct_req[i] ? IDX_W'(i) : gnt_idx_s;
    end
  end
`endif

  assign gnt_v_s       = (|eng_ct_req) & ~rst;
  assign eng_ct_gnt    = gnt_v_s ? (NUM_ENG'(1'b1) << gnt_idx_s) : {NUM_ENG{1'b0}};
  assign ct_addr       = gnt_v_s ? ct_addr_a[gnt_idx_s] : ct_addr_r;
  assign eng_ct_rvalid = rvalid_r;
  assign eng_ct_rddata = ct_rddata;

  // Read-valid follows the grant by the memory's one-cycle latency; address holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r  <= {NUM_ENG{1'b0}};
      ct_addr_r <= {ADDR_W{1'b0}};
    end else begin
      rvalid_r  <= eng_ct_gnt;
      ct_addr_r <= ct_addr;
    end
  end

  // Run sequencing, ownership lock and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rdy       <= 1'b0;
      key       <= {KEY_W{1'b0}};
      key_valid <= 1'b0;
      eng_en    <= {NUM_ENG{1'b0}};
      owner_v_r <= 1'b0;
      owner_r   <= {IDX_W{1'b0}};
    end else begin
      eng_en <= {NUM_ENG{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (en && rdy) begin
            state_r   <= ST_LAUNCH;
            rdy       <= 1'b0;
            key_valid <= 1'b0;
            owner_v_r <= 1'b0;
          end else begin
            rdy <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          if (&eng_rdy) begin
            eng_en  <= {NUM_ENG{1'b1}};
            state_r <= ST_ARM;
          end else begin
            state_r <= ST_LAUNCH;
          end
        end
        ST_ARM: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          owner_v_r <= owner_v_s;
          owner_r   <= owner_s;
          if (owner_v_s && eng_rdy[owner_s]) begin
            key       <= eng_key_a[owner_s];
            key_valid <= eng_key_valid[owner_s];
            rdy       <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (!owner_v_s && (&eng_rdy)) begin
            key_valid <= 1'b0;
            rdy       <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rdy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench for crack_sched (NUM_ENG=2); engines and the CT memory are driven by the bench.
module tb_crack_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic        key_valid;
  logic [1:0]  eng_en;
  logic [47:0] eng_start_key;
  logic [1:0]  eng_rdy;
  logic [47:0] eng_key;
  logic [1:0]  eng_key_valid;
  logic [1:0]  eng_ct_req;
  logic [15:0] eng_ct_addr;
  logic [1:0]  eng_ct_gnt;
  logic [1:0]  eng_ct_rvalid;
  logic [7:0]  eng_ct_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_rddata;
  logic [1:0]  eng_fpt_wren;
  logic [15:0] eng_fpt_addr;
  logic [15:0] eng_fpt_wrdata;
  logic        fpt_wren;
  logic [7:0]  fpt_addr;
  logic [7:0]  fpt_wrdata;

  int checks = 0;
  int failures = 0;

  crack_sched dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
    .eng_en(eng_en), .eng_start_key(eng_start_key), .eng_rdy(eng_rdy), .eng_key(eng_key),
    .eng_key_valid(eng_key_valid), .eng_ct_req(eng_ct_req), .eng_ct_addr(eng_ct_addr),
    .eng_ct_gnt(eng_ct_gnt), .eng_ct_rvalid(eng_ct_rvalid), .eng_ct_rddata(eng_ct_rddata),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata), .eng_fpt_wren(eng_fpt_wren),
    .eng_fpt_addr(eng_fpt_addr), .eng_fpt_wrdata(eng_fpt_wrdata), .fpt_wren(fpt_wren),
    .fpt_addr(fpt_addr), .fpt_wrdata(fpt_wrdata)
  );

  always #5 clk = ~clk;

  // CT memory model: content = address ^ 0x5A, one-cycle read latency
  always @(posedge clk) ct_rddata <= ct_addr ^ 8'h5A;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; eng_rdy = 2'b11; eng_key = 48'h0; eng_key_valid = 2'b00;
    eng_ct_req = 2'b00; eng_ct_addr = 16'h0; eng_fpt_wren = 2'b00;
    eng_fpt_addr = 16'h0; eng_fpt_wrdata = 16'h0;
    #1;
    chk("reset_rdy", 64'(rdy), 64'd0);
    chk("reset_key", 64'(key), 64'd0);
    chk("reset_key_valid", 64'(key_valid), 64'd0);
    chk("reset_eng_en", 64'(eng_en), 64'd0);
    chk("reset_fpt_wren", 64'(fpt_wren), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_rdy_before_edge", 64'(rdy), 64'd0);
    tick();
    chk("reset_rdy_after_release", 64'(rdy), 64'd1);
    chk("start_keys", 64'(eng_start_key), {16'h0, 24'd1, 24'd0});
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_gnt [4];
    logic [7:0] exp_addr;
`ifdef CRACK_SCHED_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    eng_ct_addr = {8'h20, 8'h10};
    eng_ct_req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_addr = (exp_gnt[c] == 2'b01) ? 8'h10 : 8'h20;
      chk("arb_gnt", 64'(eng_ct_gnt), 64'(exp_gnt[c]));
      chk("arb_ct_addr", 64'(ct_addr), 64'(exp_addr));
      if (c > 0) begin
        exp_addr = (exp_gnt[c-1] == 2'b01) ? 8'h10 : 8'h20;
        chk("arb_rvalid", 64'(eng_ct_rvalid), 64'(exp_gnt[c-1]));
        chk("arb_rddata", 64'(eng_ct_rddata), 64'(exp_addr ^ 8'h5A));
      end
      tick();
    end
    eng_ct_req = 2'b00;
    #1;
    chk("arb_idle_gnt", 64'(eng_ct_gnt), 64'd0);
    chk("arb_idle_addr_hold", 64'(ct_addr), 64'((exp_gnt[3] == 2'b01) ? 8'h10 : 8'h20));
    chk("arb_last_rvalid", 64'(eng_ct_rvalid), 64'(exp_gnt[3]));
    tick();
    chk("arb_rvalid_clear", 64'(eng_ct_rvalid), 64'd0);
  endtask

  task automatic test_launch();
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("launch_rdy_low", 64'(rdy), 64'd0);
    chk("launch_no_pulse_yet", 64'(eng_en), 64'd0);
    tick();
    chk("launch_eng_en", 64'(eng_en), 64'd3);
    eng_rdy = 2'b00;
    tick();
    chk("launch_pulse_one_cycle", 64'(eng_en), 64'd0);
    chk("launch_rdy_busy", 64'(rdy), 64'd0);
  endtask

  task automatic test_crack();
    for (int j = 0; j < 54; j++) begin
      eng_fpt_wren = 2'b01;
      eng_fpt_addr = {8'h00, 8'(j)};
      eng_fpt_wrdata = {8'h00, 8'(j) ^ 8'hC3};
      #1;
      chk("crack_fpt_wren", 64'(fpt_wren), 64'd1);
      chk("crack_fpt_addr", 64'(fpt_addr), 64'(j));
      chk("crack_fpt_data", 64'(fpt_wrdata), 64'(8'(j) ^ 8'hC3));
      tick();
    end
    eng_fpt_wren = 2'b00;
    chk("crack_still_busy", 64'(rdy), 64'd0);
    eng_key = {24'h0, 24'h18};
    eng_key_valid = 2'b01;
    eng_rdy = 2'b01;
    tick();
    chk("crack_rdy", 64'(rdy), 64'd1);
    chk("crack_key", 64'(key), 64'h18);
    chk("crack_key_valid", 64'(key_valid), 64'd1);
  endtask

  task automatic test_tie_drop();
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("tie_kv_cleared", 64'(key_valid), 64'd0);
    tick();
    tick();
    chk("tie_wait_straggler", 64'(eng_en), 64'd0);
    eng_rdy = 2'b11;
    tick();
    chk("tie_eng_en", 64'(eng_en), 64'd3);
    eng_rdy = 2'b00;
    tick();
    eng_fpt_wren = 2'b11;
    eng_fpt_addr = {8'h06, 8'h05};
    eng_fpt_wrdata = {8'hBB, 8'hAA};
    #1;
    chk("tie_wren", 64'(fpt_wren), 64'd1);
    chk("tie_owner_addr", 64'(fpt_addr), 64'h05);
    chk("tie_owner_data", 64'(fpt_wrdata), 64'hAA);
    tick();
    eng_fpt_wren = 2'b10;
    #1;
    chk("tie_drop_eng1", 64'(fpt_wren), 64'd0);
    tick();
    eng_fpt_wren = 2'b01;
    eng_fpt_addr = {8'h06, 8'h07};
    eng_fpt_wrdata = {8'hBB, 8'hCC};
    #1;
    chk("tie_owner_later_addr", 64'(fpt_addr), 64'h07);
    chk("tie_owner_later_data", 64'(fpt_wrdata), 64'hCC);
    tick();
    eng_fpt_wren = 2'b00;
    eng_key = {24'h0, 24'h77};
    eng_key_valid = 2'b00;
    eng_rdy = 2'b01;
    tick();
    chk("tie_done_rdy", 64'(rdy), 64'd1);
    chk("tie_done_kv", 64'(key_valid), 64'd0);
    chk("tie_done_key", 64'(key), 64'h77);
    eng_fpt_wren = 2'b10;
    #1;
    chk("tie_idle_drop_eng1", 64'(fpt_wren), 64'd0);
    eng_fpt_wren = 2'b00;
  endtask

  task automatic test_exhaust();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("exh_wait_eng_rdy", 64'(eng_en), 64'd0);
    eng_rdy = 2'b11;
    tick();
    chk("exh_eng_en", 64'(eng_en), 64'd3);
    eng_rdy = 2'b00;
    tick();
    tick();
    chk("exh_busy", 64'(rdy), 64'd0);
    eng_rdy = 2'b11;
    eng_key_valid = 2'b00;
    tick();
    chk("exh_rdy", 64'(rdy), 64'd1);
    chk("exh_kv", 64'(key_valid), 64'd0);
    chk("exh_key_unchanged", 64'(key), 64'h77);
  endtask

  task automatic test_reset_mid_run();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    eng_rdy = 2'b00;
    tick();
    eng_ct_req = 2'b11;
    eng_fpt_wren = 2'b01;
    eng_fpt_addr = {8'h00, 8'h33};
    #1;
    chk("mid_run_gnt", 64'(eng_ct_gnt), 64'd1);
    chk("mid_run_fpt_wren", 64'(fpt_wren), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rdy", 64'(rdy), 64'd0);
    chk("rst_mid_eng_en", 64'(eng_en), 64'd0);
    chk("rst_mid_gnt", 64'(eng_ct_gnt), 64'd0);
    chk("rst_mid_fpt_wren", 64'(fpt_wren), 64'd0);
    chk("rst_mid_key", 64'(key), 64'd0);
    eng_ct_req = 2'b00;
    eng_fpt_wren = 2'b00;
    eng_rdy = 2'b11;
    tick();
    rst = 1'b0;
    chk("rst_mid_rdy_held", 64'(rdy), 64'd0);
    tick();
    chk("rst_mid_rdy_release", 64'(rdy), 64'd1);
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_launch();
    test_crack();
    test_tie_drop();
    test_exhaust();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
